// File: rtl/exec_step_ctrl_pkg.sv
// Shared types and defaults for the CPU execution step/run controller.
package exec_step_ctrl_pkg;

    typedef enum logic [1:0] {
        HALT       = 2'd0,
        STEP_ISSUE = 2'd1,
        STEP_WAIT  = 2'd2,
        RUN        = 2'd3
    } exec_state_e;

    localparam int STEP_TIMEOUT_DEF = 1024;

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchronizer plus registered rising-edge detect for one debounced button level.
module btn_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic lvl,
    output logic evt
);

    logic       sync1, sync2, dly;
    logic [1:0] arm_cnt;
    logic       armed;

    // A level already high when reset releases is a baseline, not a press:
    // edges are only reported once the sync/delay chain has filled.
    assign armed = (arm_cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            dly     <= 1'b0;
            evt     <= 1'b0;
            arm_cnt <= 2'd0;
        end else begin
            sync1 <= lvl;
            sync2 <= sync1;
            dly   <= sync2;
            evt   <= armed & sync2 & ~dly;
            if (!armed) arm_cnt <= arm_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/exec_step_ctrl.sv
// Halt/step/run control of the CPU clock-enable, with step timeout and retired-instruction count.
module exec_step_ctrl
    import exec_step_ctrl_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int STEP_TIMEOUT = STEP_TIMEOUT_DEF,
    parameter int TMO_W        = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step_lvl,
    input  logic             run_lvl,
    input  logic             cpu_done,
    input  logic             cpu_halt,
    input  logic             clr_count,
    output logic             cpu_en,
    output logic             running,
    output logic             step_err,
    output logic [CNT_W-1:0] instr_count
);

    logic             step_evt, run_evt;
    exec_state_e      state_q, state_d;
    logic [TMO_W-1:0] tmo_q;
    logic             tmo_hit;
    logic             set_err;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;

    btn_edge_sync u_step_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .lvl   (step_lvl),
        .evt   (step_evt)
    );

    btn_edge_sync u_run_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .lvl   (run_lvl),
        .evt   (run_evt)
    );

    assign tmo_hit = (tmo_q == TMO_W'(STEP_TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        set_err = 1'b0;
        case (state_q)
            HALT: begin
                if (run_evt)       state_d = RUN;
                else if (step_evt) state_d = STEP_ISSUE;
            end
            STEP_ISSUE: state_d = STEP_WAIT;
            STEP_WAIT: begin
                if (cpu_done || cpu_halt) begin
                    state_d = HALT;
                end else if (tmo_hit) begin
                    state_d = HALT;
                    set_err = 1'b1;
                end
            end
            RUN: begin
                if (cpu_halt || run_evt) state_d = HALT;
            end
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= HALT;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == STEP_ISSUE)     tmo_q <= '0;
            else if (state_q == STEP_WAIT) tmo_q <= tmo_q + 1'b1;
            err_q <= err_q | set_err;
            // Clear wins over a coincident retire.
            if (clr_count)     cnt_q <= '0;
            else if (cpu_done) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cpu_en      = (state_q == STEP_ISSUE) || (state_q == RUN);
    assign running     = (state_q == RUN);
    assign step_err    = err_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_exec_step_ctrl.sv
// Directed bench for exec_step_ctrl with an instruction-count scoreboard.
module tb_exec_step_ctrl;

    localparam int CNT_W        = 12;
    localparam int STEP_TIMEOUT = 8;
    localparam int TMO_W        = 11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic step_lvl = 1'b0, run_lvl = 1'b0;
    logic cpu_done = 1'b0, cpu_halt = 1'b0, clr_count = 1'b0;
    logic cpu_en, running, step_err;
    logic [CNT_W-1:0] instr_count;

    int n_cmp = 0;
    int n_bad = 0;
    int unsigned exp_q[$];
    int unsigned model_cnt = 0;

    always #5 clk = ~clk;

    exec_step_ctrl #(
        .CNT_W        (CNT_W),
        .STEP_TIMEOUT (STEP_TIMEOUT),
        .TMO_W        (TMO_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .step_lvl    (step_lvl),
        .run_lvl     (run_lvl),
        .cpu_done    (cpu_done),
        .cpu_halt    (cpu_halt),
        .clr_count   (clr_count),
        .cpu_en      (cpu_en),
        .running     (running),
        .step_err    (step_err),
        .instr_count (instr_count)
    );

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_model(input int unsigned n);
        model_cnt = (model_cnt + n) % (32'd1 << CNT_W);
        exp_q.push_back(model_cnt);
    endtask

    task automatic chk_cnt(input string tag);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s: observed %0d expected <scoreboard empty>", tag, instr_count);
        end else begin
            chk(tag, 32'(instr_count), exp_q.pop_front());
        end
    endtask

    task automatic done_pulses(input int n);
        cpu_done = 1'b1;
        tick(n);
        cpu_done = 1'b0;
        push_model(n);
    endtask

    task automatic clear_cnt(input logic with_done);
        clr_count = 1'b1;
        cpu_done  = with_done;
        tick();
        clr_count = 1'b0;
        cpu_done  = 1'b0;
        model_cnt = 0;
        exp_q.push_back(0);
    endtask

    task automatic halt_pulse();
        cpu_halt = 1'b1;
        tick();
        cpu_halt = 1'b0;
    endtask

    // Raise step_lvl and watch 20 cycles; optionally answer with cpu_done.
    task automatic step_watch(input int done_at, output int pulses, output int first,
                              output logic err12, output logic err13);
        pulses = 0;
        first  = 0;
        err12  = 1'b0;
        err13  = 1'b0;
        step_lvl = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (cpu_en) begin
                pulses++;
                if (first == 0) first = k;
            end
            if (k == 12) err12 = step_err;
            if (k == 13) err13 = step_err;
            if (done_at > 0 && k == done_at) cpu_done = 1'b1;
            if (done_at > 0 && k == done_at + 1) begin
                cpu_done = 1'b0;
                push_model(1);
            end
        end
        step_lvl = 1'b0;
        tick(5);
    endtask

    initial begin
        int   pulses, first, en_hi, bad_issue;
        logic e12, e13;

        // Reset with step held high
        step_lvl = 1'b1;
        tick(3);
        chk("rst_cpu_en", 32'(cpu_en), 0);
        chk("rst_running", 32'(running), 0);
        chk("rst_step_err", 32'(step_err), 0);
        chk("rst_count", 32'(instr_count), 0);
        rst_n = 1'b1;
        en_hi = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (cpu_en) en_hi++;
        end
        chk("rst_release_no_step", 32'(en_hi), 0);
        step_lvl = 1'b0;
        tick(5);

        // Single step, answered 5 cycles after the enable pulse
        step_watch(9, pulses, first, e12, e13);
        chk("step_pulses", 32'(pulses), 1);
        chk("step_latency", 32'(first), 4);
        chk_cnt("step_count");
        chk("step_running", 32'(running), 0);
        chk("step_no_err", 32'(step_err), 0);

        // Run / stop
        run_lvl = 1'b1;
        tick(4);
        chk("run_cpu_en", 32'(cpu_en), 1);
        chk("run_running", 32'(running), 1);
        clear_cnt(1'b0);
        chk_cnt("run_clr");
        for (int i = 0; i < 10; i++) begin
            done_pulses(1);
            tick();
            chk_cnt("run_count");
            chk("run_en_hold", 32'(cpu_en & running), 1);
        end
        halt_pulse();
        chk("halt_cpu_en", 32'(cpu_en), 0);
        chk("halt_running", 32'(running), 0);
        tick(3);
        chk("halt_stays", 32'(cpu_en), 0);
        run_lvl = 1'b0;
        tick(5);

        // Step with no cpu_done: timeout after 8 wait cycles
        step_watch(0, pulses, first, e12, e13);
        chk("tmo_pulses", 32'(pulses), 1);
        chk("tmo_err_before", 32'(e12), 0);
        chk("tmo_err_set", 32'(e13), 1);
        chk("tmo_cpu_en", 32'(cpu_en), 0);

        // Following good step keeps the sticky error
        step_watch(6, pulses, first, e12, e13);
        chk("step2_pulses", 32'(pulses), 1);
        chk_cnt("step2_count");
        chk("err_sticky", 32'(step_err), 1);

        // Step and run rise together: run wins
        step_lvl  = 1'b1;
        run_lvl   = 1'b1;
        bad_issue = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (cpu_en !== running) bad_issue++;
            if (k == 4) chk("both_running", 32'(running), 1);
        end
        chk("both_no_issue", 32'(bad_issue), 0);
        halt_pulse();
        chk("both_halt", 32'(running), 0);
        step_lvl = 1'b0;
        run_lvl  = 1'b0;
        tick(5);
        chk("both_idle", 32'(cpu_en), 0);

        // Counter wrap and clear priority (retires in HALT still count)
        clear_cnt(1'b0);
        chk_cnt("wrap_clr");
        done_pulses((1 << CNT_W) - 1);
        chk_cnt("wrap_allones");
        done_pulses(1);
        chk_cnt("wrap_zero");
        done_pulses(1);
        chk_cnt("wrap_one");
        clear_cnt(1'b1);
        chk_cnt("clr_beats_done");

        // Mid-run reset
        run_lvl = 1'b1;
        tick(4);
        chk("mid_running", 32'(running), 1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_cpu_en", 32'(cpu_en), 0);
        chk("mid_rst_err", 32'(step_err), 0);
        rst_n   = 1'b1;
        run_lvl = 1'b0;
        tick(5);
        chk("mid_rst_idle", 32'(running), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/exec_step_ctrl.md
Name: exec_step_ctrl

Overview:
- Consumes the debounced button levels from the board chattering filter and turns them into CPU execution control.
- Synchronizes the levels, detects rising edges, and runs a halt/step/run FSM that gates the processor clock-enable.
- Counts retired instructions.
- Sits between the button debouncers and the CPU core's enable/done interface.

Parameters:
CNT_W, 16, width of retired-instruction counter
STEP_TIMEOUT, 1024, max cycles to wait for cpu_done after a single step before flagging error
TMO_W, 11, width of timeout counter (must hold STEP_TIMEOUT)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset, sampled on posedge clk
step_lvl  in  1  debounced step-button level, asynchronous to clk
run_lvl  in  1  debounced run/stop-button level, asynchronous to clk
cpu_done  in  1  one-cycle pulse from CPU: instruction retired
cpu_halt  in  1  one-cycle pulse from CPU: HLT instruction executed
clr_count  in  1  synchronous clear of instr_count
cpu_en  out  1  clock-enable to CPU
running  out  1  high while in RUN
step_err  out  1  sticky: single step timed out
instr_count  out  CNT_W  retired-instruction count

Behaviour:
- Reset:
  - All flops are cleared when rst_n=0 at posedge clk.
  - Outputs: cpu_en=0, running=0, step_err=0, instr_count=0.
  - State=HALT; synchronizer and edge registers are 0.
  - A mid-operation reset returns to HALT within the same edge, and any in-flight step is dropped.
- Input path, per input:
  - 2-flop synchronizer, then a delay flop.
  - evt = sync & ~delay, giving a one-cycle event.
  - Input-to-event latency is 3 clk edges.
  - A level held high produces exactly one event.
- FSM states: HALT, STEP_ISSUE, STEP_WAIT, RUN.
- HALT:
  - run_evt -> RUN.
  - Otherwise step_evt -> STEP_ISSUE.
  - If both events occur in the same cycle, run wins and the step is discarded.
- STEP_ISSUE:
  - cpu_en=1 for exactly this one cycle; then -> STEP_WAIT.
  - Clears the timeout counter.
- STEP_WAIT:
  - cpu_en=0.
  - cpu_done or cpu_halt -> HALT.
  - Timeout counter increments each cycle. When it reaches STEP_TIMEOUT-1 without done/halt -> HALT and set step_err.
  - step_evt and run_evt are ignored (dropped, not queued).
- RUN:
  - cpu_en=1 and running=1 every cycle.
  - cpu_halt or run_evt -> HALT. cpu_en=0 from the next cycle.
  - step_evt is ignored.
- step_err:
  - Sticky; cleared only by reset.
  - A later successful step does not clear it.
- instr_count:
  - Increments on cpu_done in any state. cpu_done arriving in HALT is still counted.
  - Wraps modulo 2^CNT_W (all-ones + 1 = 0).
  - clr_count has priority over increment: the counter is 0 on the next cycle even if cpu_done is coincident.
- Output registration:
  - All outputs are registered, decoded from the state register (Moore).
  - cpu_en rises on the edge that enters STEP_ISSUE or RUN.

Decomposition:
- Shared package:
  - FSM state enum (HALT=2'd0, STEP_ISSUE=2'd1, STEP_WAIT=2'd2, RUN=2'd3).
  - Default STEP_TIMEOUT constant.
- Sub-module btn_edge_sync:
  - 2-flop synchronizer plus rising-edge detect, with the same clk/rst_n.
  - Instantiated twice, for step and run.
- FSM, timeout counter and instruction counter stay in the top module.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with step_lvl=1 -> all outputs 0.
  - Release with step_lvl still 1 -> no step (the delay flop is also 1 after sync), cpu_en stays 0.
- Single step: step_lvl 0->1, hold 20 cycles -> exactly one cpu_en pulse, 1 cycle wide, 4 edges after the input change.
  - cpu_done 5 cycles later -> HALT, instr_count=1.
- Run/stop: run_lvl 0->1:
  - cpu_en=1 and running=1 continuously.
  - Drive 10 cpu_done pulses -> instr_count=10.
  - cpu_halt -> cpu_en=0 the next cycle, running=0.
- Timeout: STEP_TIMEOUT=8, step with no cpu_done -> HALT after 8 wait cycles, step_err=1.
  - A following normal step completes and step_err stays 1.
- Simultaneous events: step_lvl and run_lvl rise on the same cycle in HALT -> RUN entered, no STEP_ISSUE observed.
- Counter edges:
  - Preload via 65535 done pulses, then 1 more -> instr_count wraps to 0.
  - clr_count and cpu_done in the same cycle -> 0.
